// File: rtl/freq_div_scheduler.sv
// Shared sequential divider producing DIVIDEND / freq for the left and right tone channels.
// Channels are recomputed round-robin whenever their accepted frequency or the octave changes.
module freq_div_scheduler #(
  parameter int unsigned DIVIDEND = 100_000_000,
  parameter int unsigned SILENCE  = 100_000_000,
  parameter int unsigned IN_W     = 32,
  parameter int unsigned OUT_W    = 22
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  freqL,
  input  logic [IN_W-1:0]  freqR,
  input  logic [2:0]       octave,
  output logic [OUT_W-1:0] div_outL,
  output logic [OUT_W-1:0] div_outR,
  output logic             busy,
  output logic             doneL,
  output logic             doneR
);

  localparam int unsigned CNT_W = $clog2(IN_W);
  localparam logic [IN_W-1:0] SIL = IN_W'(SILENCE);
  localparam logic [IN_W-1:0] DVD = IN_W'(DIVIDEND);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_DIV   = 2'd2;
  localparam logic [1:0] S_STORE = 2'd3;

  logic [1:0]       state;
  logic             sel;
  logic             rr;
  logic [IN_W-1:0]  acc_l;
  logic [IN_W-1:0]  acc_r;
  logic [2:0]       acc_oct;
  logic             stale_l;
  logic             stale_r;
  logic [IN_W-1:0]  divisor;
  logic [IN_W-1:0]  dvd_sh;
  logic [IN_W-1:0]  rem;
  logic [IN_W-1:0]  quot;
  logic [CNT_W-1:0] cnt;
  logic             zero_div;

  logic             pend_l;
  logic             pend_r;
  logic             pick_r;
  logic [IN_W-1:0]  sel_freq;
  logic [IN_W-1:0]  divisor_next;
  logic [IN_W:0]    trial;
  logic             ge;
  logic [OUT_W-1:0] result;

  assign pend_l = (freqL != acc_l) | (octave != acc_oct) | stale_l;
  assign pend_r = (freqR != acc_r) | (octave != acc_oct) | stale_r;
  assign pick_r = pend_r & (~pend_l | rr);
  assign sel_freq = sel ? freqR : freqL;
  assign busy = (state != S_IDLE);

  // A rest keeps its SILENCE divisor regardless of octave so the quotient is exactly 1.
  always_comb begin
    divisor_next = sel_freq;
    if (sel_freq == SIL)
      divisor_next = SIL;
    else if (octave == 3'd1)
      divisor_next = sel_freq >> 1;
    else if (octave == 3'd3)
      divisor_next = sel_freq << 1;
  end

  assign trial  = {rem, dvd_sh[IN_W-1]};
  assign ge     = (trial >= {1'b0, divisor});
  assign result = (zero_div || (|quot[IN_W-1:OUT_W])) ? '1 : quot[OUT_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      sel      <= 1'b0;
      rr       <= 1'b0;
      acc_l    <= SIL;
      acc_r    <= SIL;
      acc_oct  <= 3'd2;
      stale_l  <= 1'b0;
      stale_r  <= 1'b0;
      divisor  <= '0;
      dvd_sh   <= '0;
      rem      <= '0;
      quot     <= '0;
      cnt      <= '0;
      zero_div <= 1'b0;
      div_outL <= OUT_W'(1);
      div_outR <= OUT_W'(1);
      doneL    <= 1'b0;
      doneR    <= 1'b0;
    end else begin
      doneL <= 1'b0;
      doneR <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pend_l || pend_r) begin
            sel   <= pick_r;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (sel) acc_r <= freqR;
          else     acc_l <= freqL;
          acc_oct <= octave;
          // Accepting a new octave leaves the other channel's held result stale.
          if (octave != acc_oct) begin
            if (sel) stale_l <= 1'b1;
            else     stale_r <= 1'b1;
          end
          divisor  <= divisor_next;
          zero_div <= (divisor_next == '0);
          dvd_sh   <= DVD;
          rem      <= '0;
          quot     <= '0;
          cnt      <= '0;
          state    <= S_DIV;
        end
        S_DIV: begin
          rem    <= ge ? IN_W'(trial - {1'b0, divisor}) : trial[IN_W-1:0];
          dvd_sh <= dvd_sh << 1;
          quot   <= {quot[IN_W-2:0], ge};
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_W'(IN_W - 1))
            state <= S_STORE;
        end
        default: begin
          if (sel) begin
            div_outR <= result;
            doneR    <= 1'b1;
            stale_r  <= 1'b0;
          end else begin
            div_outL <= result;
            doneL    <= 1'b1;
            stale_l  <= 1'b0;
          end
          rr    <= ~sel;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_div_scheduler.sv
// Self-checking bench for freq_div_scheduler: directed latency/ordering scenarios plus
// randomized settle-and-compare against an arithmetic reference model.
module tb_freq_div_scheduler;

  localparam int unsigned SIL = 100_000_000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] freqL = SIL;
  logic [31:0] freqR = SIL;
  logic [2:0]  octave = 3'd2;
  logic [21:0] div_outL;
  logic [21:0] div_outR;
  logic        busy;
  logic        doneL;
  logic        doneR;

  int checks = 0;
  int errors = 0;

  freq_div_scheduler dut (
    .clk(clk), .rst_n(rst_n), .freqL(freqL), .freqR(freqR), .octave(octave),
    .div_outL(div_outL), .div_outR(div_outR), .busy(busy), .doneL(doneL), .doneR(doneR)
  );

  always #5 clk = ~clk;

  // Reference: what note_gen should get for a raw frequency and octave setting.
  function automatic logic [21:0] ref_div(input logic [31:0] f, input logic [2:0] o);
    longint unsigned d;
    longint unsigned q;
    if (f == SIL) return 22'd1;
    if (o == 3'd1)      d = longint'(f) / 2;
    else if (o == 3'd3) d = (longint'(f) * 2) % (64'd1 << 32);
    else                d = longint'(f);
    if (d == 0) return 22'h3FFFFF;
    q = 64'd100_000_000 / d;
    if (q >= (64'd1 << 22)) return 22'h3FFFFF;
    return q[21:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    freqL = SIL;
    freqR = SIL;
    octave = 3'd2;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic settle(output int n_l, output int n_r);
    int quiet = 0;
    int n = 0;
    n_l = 0;
    n_r = 0;
    while (quiet < 3 && n < 400) begin
      tick();
      n++;
      if (doneL) n_l++;
      if (doneR) n_r++;
      quiet = busy ? 0 : quiet + 1;
    end
    checks++;
    if (quiet < 3) begin
      errors++;
      $display("[TB] FAIL settle_timeout busy=%b after %0d cycles, required idle", busy, n);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (div_outL !== 22'd1 || div_outR !== 22'd1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state L=%0d R=%0d busy=%b, required 1 1 0", div_outL, div_outR, busy);
    end
    for (int i = 0; i < 100; i++) begin
      tick();
      checks++;
      if (busy !== 1'b0 || doneL !== 1'b0 || doneR !== 1'b0 || div_outL !== 22'd1 || div_outR !== 22'd1) begin
        errors++;
        $display("[TB] FAIL silent_hold cyc=%0d L=%0d R=%0d busy=%b dL=%b dR=%b, required 1 1 0 0 0",
                 i, div_outL, div_outR, busy, doneL, doneR);
      end
    end
  endtask

  task automatic test_single();
    freqL = 32'd262;
    for (int i = 1; i <= 36; i++) begin
      tick();
      if (i == 34) begin
        checks++;
        if (doneL !== 1'b0 || div_outL !== 22'd1) begin
          errors++;
          $display("[TB] FAIL single_early L=%0d doneL=%b, required 1 0", div_outL, doneL);
        end
      end
      if (i == 35) begin
        checks++;
        if (doneL !== 1'b1 || div_outL !== ref_div(262, 2) || div_outR !== 22'd1) begin
          errors++;
          $display("[TB] FAIL single_k35 L=%0d doneL=%b R=%0d, required %0d 1 1",
                   div_outL, doneL, div_outR, ref_div(262, 2));
        end
      end
      if (i == 36) begin
        checks++;
        if (doneL !== 1'b0) begin
          errors++;
          $display("[TB] FAIL single_pulse_width doneL=%b, required 0", doneL);
        end
      end
    end
  endtask

  task automatic test_octave();
    int n_l, n_r;
    logic [2:0] octs [2] = '{3'd1, 3'd3};
    for (int k = 0; k < 2; k++) begin
      octave = octs[k];
      settle(n_l, n_r);
      checks++;
      if (div_outL !== ref_div(262, octs[k]) || div_outR !== 22'd1 || n_l != 1 || n_r != 1) begin
        errors++;
        $display("[TB] FAIL octave_%0d L=%0d R=%0d nL=%0d nR=%0d, required %0d 1 1 1",
                 octs[k], div_outL, div_outR, n_l, n_r, ref_div(262, octs[k]));
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    freqL = 32'd440;
    freqR = 32'd330;
    for (int i = 1; i <= 70; i++) begin
      tick();
      if (i == 35) begin
        checks++;
        if (doneL !== 1'b1 || div_outL !== ref_div(440, 2) || doneR !== 1'b0 || div_outR !== 22'd1) begin
          errors++;
          $display("[TB] FAIL b2b_first L=%0d dL=%b R=%0d dR=%b, required %0d 1 1 0",
                   div_outL, doneL, div_outR, doneR, ref_div(440, 2));
        end
      end
      if (i == 69) begin
        checks++;
        if (doneR !== 1'b0 || div_outR !== 22'd1) begin
          errors++;
          $display("[TB] FAIL b2b_early R=%0d dR=%b, required 1 0", div_outR, doneR);
        end
      end
      if (i == 70) begin
        checks++;
        if (doneR !== 1'b1 || div_outR !== ref_div(330, 2) || div_outL !== ref_div(440, 2)) begin
          errors++;
          $display("[TB] FAIL b2b_second R=%0d dR=%b L=%0d, required %0d 1 %0d",
                   div_outR, doneR, div_outL, ref_div(330, 2), ref_div(440, 2));
        end
      end
    end
  endtask

  task automatic test_saturate();
    int n_l, n_r;
    logic [31:0] fs [2] = '{32'd0, 32'd20};
    for (int k = 0; k < 2; k++) begin
      freqR = fs[k];
      settle(n_l, n_r);
      checks++;
      if (div_outR !== 22'h3FFFFF || n_r != 1) begin
        errors++;
        $display("[TB] FAIL saturate_f%0d R=%h nR=%0d, required 3fffff 1", fs[k], div_outR, n_r);
      end
    end
  endtask

  task automatic test_mid_change();
    do_reset();
    freqL = 32'd262;
    for (int i = 1; i <= 70; i++) begin
      tick();
      if (i == 12) freqL = 32'd294;
      if (i == 35) begin
        checks++;
        if (doneL !== 1'b1 || div_outL !== ref_div(262, 2)) begin
          errors++;
          $display("[TB] FAIL midchg_first L=%0d dL=%b, required %0d 1", div_outL, doneL, ref_div(262, 2));
        end
      end
      if (i == 70) begin
        checks++;
        if (doneL !== 1'b1 || div_outL !== ref_div(294, 2)) begin
          errors++;
          $display("[TB] FAIL midchg_second L=%0d dL=%b, required %0d 1", div_outL, doneL, ref_div(294, 2));
        end
      end
    end
  endtask

  task automatic test_reset_mid_div();
    int pulses = 0;
    int busy_seen = 0;
    freqL = 32'd440;
    repeat (15) tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (div_outL !== 22'd1 || div_outR !== 22'd1 || busy !== 1'b0 || doneL !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_div L=%0d R=%0d busy=%b dL=%b, required 1 1 0 0",
               div_outL, div_outR, busy, doneL);
    end
    freqL = SIL;
    freqR = SIL;
    octave = 3'd2;
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (doneL || doneR) pulses++;
      if (busy) busy_seen++;
    end
    checks++;
    if (pulses != 0 || busy_seen != 0 || div_outL !== 22'd1) begin
      errors++;
      $display("[TB] FAIL post_abort pulses=%0d busy_cycles=%0d L=%0d, required 0 0 1",
               pulses, busy_seen, div_outL);
    end
  endtask

  function automatic logic [31:0] rand_freq();
    int unsigned c = $urandom_range(0, 9);
    if (c == 0) return 32'd0;
    if (c == 1) return SIL;
    if (c == 2) return $urandom;
    return $urandom_range(1, 200000);
  endfunction

  task automatic test_random();
    int n_l, n_r;
    for (int k = 0; k < 12; k++) begin
      freqL = rand_freq();
      freqR = rand_freq();
      octave = 3'($urandom_range(0, 7));
      settle(n_l, n_r);
      checks++;
      if (div_outL !== ref_div(freqL, octave) || div_outR !== ref_div(freqR, octave)) begin
        errors++;
        $display("[TB] FAIL random_%0d fL=%0d fR=%0d oct=%0d L=%0d R=%0d, required %0d %0d",
                 k, freqL, freqR, octave, div_outL, div_outR,
                 ref_div(freqL, octave), ref_div(freqR, octave));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_octave();
    test_back_to_back();
    test_saturate();
    test_mid_change();
    test_reset_mid_div();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
